// File: rtl/timer_seq_ctrl.sv
// Sequencing core of the APB 8-bit timer: holds TCNT, the PCLK prescaler and the IDLE/LOAD/RUN FSM,
// and keeps the sticky overflow/underflow flags that drive the timer interrupt.
module timer_seq_ctrl #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             load_req,
    input  logic             en,
    input  logic             up_down,
    input  logic [1:0]       cks,
    input  logic [CNT_W-1:0] tdr,
    input  logic             sts_wr,
    input  logic [1:0]       sts_wdata,
    output logic [CNT_W-1:0] tcnt,
    output logic             tick,
    output logic [1:0]       tsr,
    output logic             irq,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_t;

    state_t           st;
    logic [DIV_W-1:0] presc;
    logic             load_req_q;
    logic [1:0]       cks_q;

    logic             ld_edge;
    logic             cks_chg;
    logic             presc_done;
    logic             run_tick;
    logic             ovf_set;
    logic             unf_set;

    // Terminal prescaler count for divide-by 2**(cks+1).
    function automatic logic [DIV_W-1:0] presc_term(input logic [1:0] sel);
        case (sel)
            2'b00:   presc_term = DIV_W'(1);
            2'b01:   presc_term = DIV_W'(3);
            2'b10:   presc_term = DIV_W'(7);
            default: presc_term = DIV_W'(15);
        endcase
    endfunction

    assign ld_edge    = load_req & ~load_req_q;
    assign cks_chg    = (cks != cks_q);
    assign presc_done = (presc == presc_term(cks));

    // A tick only survives when nothing of higher priority claims the cycle.
    assign run_tick = (st == RUN) & ~ld_edge & en & ~cks_chg & presc_done;
    assign ovf_set  = run_tick & ~up_down & (tcnt == {CNT_W{1'b1}});
    assign unf_set  = run_tick &  up_down & (tcnt == '0);

    assign state = st;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            st         <= IDLE;
            presc      <= '0;
            load_req_q <= 1'b0;
            cks_q      <= 2'b00;
            tcnt       <= '0;
            tick       <= 1'b0;
            tsr        <= 2'b00;
            irq        <= 1'b0;
        end else begin
            load_req_q <= load_req;
            cks_q      <= cks;
            tick       <= run_tick;
            // A flag set in the same cycle as its clear strobe wins.
            tsr[0]     <= ovf_set | (tsr[0] & ~(sts_wr & sts_wdata[0]));
            tsr[1]     <= unf_set | (tsr[1] & ~(sts_wr & sts_wdata[1]));
            irq        <= tsr[1] | tsr[0];

            case (st)
                IDLE: begin
                    if (ld_edge)
                        st <= LOAD;
                    else if (en)
                        st <= RUN;
                end
                LOAD: begin
                    tcnt  <= tdr;
                    presc <= '0;
                    st    <= en ? RUN : IDLE;
                end
                RUN: begin
                    if (ld_edge) begin
                        st <= LOAD;
                    end else if (!en) begin
                        st    <= IDLE;
                        presc <= '0;
                    end else if (cks_chg) begin
                        presc <= '0;
                    end else if (presc_done) begin
                        presc <= '0;
                        // Modular arithmetic gives the MAX->0 and 0->MAX wraps.
                        tcnt  <= up_down ? tcnt - CNT_W'(1) : tcnt + CNT_W'(1);
                    end else begin
                        presc <= presc + DIV_W'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl: load, wrap in both directions, flag clear races,
// enable drop/re-enable, load/tick collision and asynchronous reset.
module tb_timer_seq_ctrl;

    logic       PCLK;
    logic       PRESETn;
    logic       load_req;
    logic       en;
    logic       up_down;
    logic [1:0] cks;
    logic [7:0] tdr;
    logic       sts_wr;
    logic [1:0] sts_wdata;
    logic [7:0] tcnt;
    logic       tick;
    logic [1:0] tsr;
    logic       irq;
    logic [1:0] state;

    int tests;
    int errors;

    timer_seq_ctrl #(.CNT_W(8), .DIV_W(4)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .load_req  (load_req),
        .en        (en),
        .up_down   (up_down),
        .cks       (cks),
        .tdr       (tdr),
        .sts_wr    (sts_wr),
        .sts_wdata (sts_wdata),
        .tcnt      (tcnt),
        .tick      (tick),
        .tsr       (tsr),
        .irq       (irq),
        .state     (state)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    // Leaves the bench just after the LOAD->RUN edge with the prescaler at zero.
    task automatic load_value(input logic [7:0] v);
        tdr      = v;
        load_req = 1'b1;
        cyc();
        load_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; load_req = 0; en = 0; up_down = 0; cks = 0;
        tdr = 8'h00; sts_wr = 0; sts_wdata = 0;
        repeat (2) cyc();
        tests++; if (tcnt !== 8'h00) begin errors++; $display("FAIL rst_tcnt got %h exp 00", tcnt); end
        tests++; if (tsr !== 2'b00) begin errors++; $display("FAIL rst_tsr got %b exp 00", tsr); end
        tests++; if (irq !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL rst_irq_tick got %b%b exp 00", irq, tick); end
        tests++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %b exp 00", state); end
        PRESETn = 1'b1;
        cyc();
    endtask

    task automatic test_load_up();
        tdr = 8'hF0; en = 1; up_down = 0; cks = 2'b00; load_req = 1;
        cyc();
        tests++; if (state !== 2'b01) begin errors++; $display("FAIL load_state got %b exp 01", state); end
        tests++; if (tcnt !== 8'h00) begin errors++; $display("FAIL load_pre_tcnt got %h exp 00", tcnt); end
        load_req = 0;
        cyc();
        tests++; if (state !== 2'b10 || tcnt !== 8'hF0) begin errors++; $display("FAIL load_done got %b/%h exp 10/F0", state, tcnt); end
        cyc();
        tests++; if (tcnt !== 8'hF0 || tick !== 1'b0) begin errors++; $display("FAIL first_wait got %h/%b exp F0/0", tcnt, tick); end
        cyc();
        tests++; if (tcnt !== 8'hF1 || tick !== 1'b1) begin errors++; $display("FAIL first_tick got %h/%b exp F1/1", tcnt, tick); end
        cyc();
        tests++; if (tick !== 1'b0) begin errors++; $display("FAIL tick_pulse got %b exp 0", tick); end
        cyc();
        tests++; if (tcnt !== 8'hF2 || tick !== 1'b1) begin errors++; $display("FAIL second_tick got %h/%b exp F2/1", tcnt, tick); end
    endtask

    task automatic test_wrap_up();
        load_value(8'hFE);
        tests++; if (tcnt !== 8'hFE) begin errors++; $display("FAIL wrap_load got %h exp FE", tcnt); end
        repeat (2) cyc();
        tests++; if (tcnt !== 8'hFF || tsr !== 2'b00) begin errors++; $display("FAIL up_ff got %h/%b exp FF/00", tcnt, tsr); end
        repeat (2) cyc();
        tests++; if (tcnt !== 8'h00 || tsr !== 2'b01 || irq !== 1'b0) begin errors++; $display("FAIL up_wrap got %h/%b/%b exp 00/01/0", tcnt, tsr, irq); end
        cyc();
        tests++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_irq got %b exp 1", irq); end
        cyc();
        tests++; if (tcnt !== 8'h01 || tsr !== 2'b01) begin errors++; $display("FAIL up_cont got %h/%b exp 01/01", tcnt, tsr); end
        sts_wr = 1; sts_wdata = 2'b01;
        cyc();
        sts_wr = 0; sts_wdata = 2'b00;
        tests++; if (tsr !== 2'b00 || irq !== 1'b1) begin errors++; $display("FAIL ovf_clear got %b/%b exp 00/1", tsr, irq); end
        cyc();
        tests++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop got %b exp 0", irq); end
    endtask

    task automatic test_wrap_down();
        cks = 2'b11; up_down = 1;
        load_value(8'h02);
        repeat (15) cyc();
        tests++; if (tcnt !== 8'h02 || tick !== 1'b0) begin errors++; $display("FAIL div16_wait got %h/%b exp 02/0", tcnt, tick); end
        cyc();
        tests++; if (tcnt !== 8'h01 || tick !== 1'b1) begin errors++; $display("FAIL div16_tick got %h/%b exp 01/1", tcnt, tick); end
        repeat (16) cyc();
        tests++; if (tcnt !== 8'h00 || tsr !== 2'b00) begin errors++; $display("FAIL down_zero got %h/%b exp 00/00", tcnt, tsr); end
        repeat (16) cyc();
        tests++; if (tcnt !== 8'hFF || tsr !== 2'b10) begin errors++; $display("FAIL down_wrap got %h/%b exp FF/10", tcnt, tsr); end
        cyc();
        tests++; if (irq !== 1'b1) begin errors++; $display("FAIL unf_irq got %b exp 1", irq); end
    endtask

    task automatic test_clear_collision();
        cks = 2'b00; up_down = 0;
        load_value(8'hFF);
        cyc();
        sts_wr = 1; sts_wdata = 2'b01;
        cyc();
        tests++; if (tcnt !== 8'h00 || tsr !== 2'b11) begin errors++; $display("FAIL set_wins got %h/%b exp 00/11", tcnt, tsr); end
        sts_wdata = 2'b11;
        cyc();
        sts_wr = 0; sts_wdata = 2'b00;
        tests++; if (tsr !== 2'b00 || irq !== 1'b1) begin errors++; $display("FAIL clear_both got %b/%b exp 00/1", tsr, irq); end
        cyc();
        tests++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", irq); end
    endtask

    task automatic test_en_drop();
        load_value(8'h10);
        repeat (2) cyc();
        tests++; if (tcnt !== 8'h11) begin errors++; $display("FAIL pre_drop got %h exp 11", tcnt); end
        en = 0;
        cyc();
        tests++; if (state !== 2'b00) begin errors++; $display("FAIL drop_idle got %b exp 00", state); end
        repeat (5) cyc();
        tests++; if (tcnt !== 8'h11 || tick !== 1'b0) begin errors++; $display("FAIL frozen got %h/%b exp 11/0", tcnt, tick); end
        cks = 2'b01; en = 1;
        cyc();
        tests++; if (state !== 2'b10) begin errors++; $display("FAIL reenable got %b exp 10", state); end
        repeat (3) cyc();
        tests++; if (tcnt !== 8'h11 || tick !== 1'b0) begin errors++; $display("FAIL reen_wait got %h/%b exp 11/0", tcnt, tick); end
        cyc();
        tests++; if (tcnt !== 8'h12 || tick !== 1'b1) begin errors++; $display("FAIL reen_tick got %h/%b exp 12/1", tcnt, tick); end
        // Prescaler is now at its terminal count; a load edge must pre-empt the tick.
        repeat (3) cyc();
        tdr = 8'hA5; load_req = 1;
        cyc();
        tests++; if (state !== 2'b01 || tick !== 1'b0 || tcnt !== 8'h12) begin errors++; $display("FAIL ld_vs_tick got %b/%b/%h exp 01/0/12", state, tick, tcnt); end
        load_req = 0;
        cyc();
        tests++; if (tcnt !== 8'hA5 || tsr !== 2'b00) begin errors++; $display("FAIL ld_no_flag got %h/%b exp A5/00", tcnt, tsr); end
    endtask

    task automatic test_reset_mid_run();
        cks = 2'b00; up_down = 0;
        load_value(8'hFF);
        repeat (2) cyc();
        up_down = 1;
        load_value(8'h00);
        repeat (2) cyc();
        tests++; if (tcnt !== 8'hFF || tsr !== 2'b11) begin errors++; $display("FAIL both_flags got %h/%b exp FF/11", tcnt, tsr); end
        cyc();
        tests++; if (irq !== 1'b1 || state !== 2'b10) begin errors++; $display("FAIL pre_reset got %b/%b exp 1/10", irq, state); end
        #3 PRESETn = 1'b0;
        #1;
        tests++; if (tcnt !== 8'h00 || tsr !== 2'b00) begin errors++; $display("FAIL async_rst got %h/%b exp 00/00", tcnt, tsr); end
        tests++; if (irq !== 1'b0 || state !== 2'b00 || tick !== 1'b0) begin errors++; $display("FAIL async_rst_ctl got %b/%b/%b exp 0/00/0", irq, state, tick); end
        en = 0;
        cyc();
        PRESETn = 1'b1;
        cyc();
        tests++; if (state !== 2'b00 || tcnt !== 8'h00) begin errors++; $display("FAIL post_rst got %b/%h exp 00/00", state, tcnt); end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_load_up();
        test_wrap_up();
        test_wrap_down();
        test_clear_collision();
        test_en_drop();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
